ahb_req_queue: RTL and testbench

// - Upstream command stage for ahb_master: buffers CPU/DMA transaction requests in a request FIFO.
// - Presents requests one at a time on the master's valid/ready transaction port.
// - Captures returned read data into a response FIFO with consumer backpressure.
// - Credit counting guarantees the response FIFO never overflows; ahb_master's o_rd_valid cannot be stalled.

---
 rtl/ahb_pkg.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/ahb_req_queue.sv | 112 +++++++++++
 tb/tb_ahb_req_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared types for the AHB request queue: the request record carried through the
// request FIFO and the read/write direction encoding.
package ahb_pkg;
    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    typedef struct packed {
        logic [AHB_AW-1:0] addr;
        logic              rd0_wr1;
        logic [AHB_DW-1:0] wr_data;
    } ahb_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from the occupancy counter.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_count = r_count;
    // Head is forced to zero when empty so the unreset storage never leaks out.
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/ahb_req_queue.sv
// Command stage in front of ahb_master: request FIFO, in-order issue gated by read
// credits, and a response FIFO that can never be overrun by returning read data.
module ahb_req_queue
    import ahb_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int AW        = AHB_AW,
    parameter int DW        = AHB_DW
) (
    input  logic                             i_clk_ahb,
    input  logic                             i_rstn_ahb,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic [AW-1:0]                    i_req_addr,
    input  logic                             i_req_rd0_wr1,
    input  logic [DW-1:0]                    i_req_wr_data,
    output logic                             o_rsp_valid,
    input  logic                             i_rsp_ready,
    output logic [DW-1:0]                    o_rsp_data,
    output logic                             o_m_valid,
    output logic [AW-1:0]                    o_m_addr,
    output logic                             o_m_rd0_wr1,
    output logic [DW-1:0]                    o_m_wr_data,
    input  logic                             i_m_ready,
    input  logic                             i_m_rd_valid,
    input  logic [DW-1:0]                    i_m_rd_data,
    output logic [$clog2(REQ_DEPTH+1)-1:0]   o_req_count,
    output logic [$clog2(RSP_DEPTH+1)-1:0]   o_rd_outstanding,
    output logic                             o_err_unexp_rd
);
    localparam int CW = $clog2(RSP_DEPTH+1);

    ahb_req_t      w_req_in;
    ahb_req_t      w_head;
    logic          w_req_full;
    logic          w_req_empty;
    logic          w_issue;
    logic          w_issue_rd;
    logic          w_ret;
    logic          w_unexp;
    logic          w_rsp_full;
    logic          w_rsp_empty;
    logic          w_rsp_pop;
    logic [CW-1:0] w_rsp_count;
    logic [CW:0]   w_credit_sum;
    logic          w_credit_ok;
    logic [CW-1:0] r_rd_out;
    logic          r_err;

    assign w_req_in.addr    = i_req_addr;
    assign w_req_in.rd0_wr1 = i_req_rd0_wr1;
    assign w_req_in.wr_data = i_req_wr_data;

    // Push is gated by !full here, so the FIFO's pop-while-full admission never applies.
    sync_fifo #(.WIDTH($bits(ahb_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .i_clk   (i_clk_ahb),
        .i_rstn  (i_rstn_ahb),
        .i_push  (i_req_valid && o_req_ready),
        .i_data  (w_req_in),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_count (o_req_count),
        .o_full  (w_req_full),
        .o_empty (w_req_empty)
    );

    assign o_req_ready  = !w_req_full;
    assign w_credit_sum = {1'b0, r_rd_out} + {1'b0, w_rsp_count};
    assign w_credit_ok  = (w_credit_sum < (CW+1)'(RSP_DEPTH));

    assign o_m_valid   = !w_req_empty && ((w_head.rd0_wr1 == WR) || w_credit_ok);
    assign o_m_addr    = w_head.addr;
    assign o_m_rd0_wr1 = w_head.rd0_wr1;
    assign o_m_wr_data = w_head.wr_data;

    assign w_issue    = o_m_valid && i_m_ready;
    assign w_issue_rd = w_issue && (w_head.rd0_wr1 == RD);
    assign w_ret      = i_m_rd_valid && (r_rd_out != '0);
    assign w_rsp_pop  = o_rsp_valid && i_rsp_ready;
    assign w_unexp    = i_m_rd_valid && ((r_rd_out == '0) || (w_rsp_full && !w_rsp_pop));

    sync_fifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .i_clk   (i_clk_ahb),
        .i_rstn  (i_rstn_ahb),
        .i_push  (w_ret),
        .i_data  (i_m_rd_data),
        .i_pop   (w_rsp_pop),
        .o_data  (o_rsp_data),
        .o_count (w_rsp_count),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty)
    );

    assign o_rsp_valid      = !w_rsp_empty;
    assign o_rd_outstanding = r_rd_out;
    assign o_err_unexp_rd   = r_err;

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_rd_out <= '0;
            r_err    <= 1'b0;
        end else begin
            case ({w_issue_rd, w_ret})
                2'b10:   r_rd_out <= r_rd_out + CW'(1);
                2'b01:   r_rd_out <= r_rd_out - CW'(1);
                default: r_rd_out <= r_rd_out;
            endcase
            if (w_unexp) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_req_queue.sv
// Directed bench for ahb_req_queue: write burst, full FIFO, read credit, ordering,
// simultaneous events, error flag and mid-burst reset.
module tb_ahb_req_queue;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic        m_rd_valid = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic [2:0]  req_count;
    logic [2:0]  rd_out;
    logic        err;

    int checks = 0;
    int failures = 0;

    ahb_req_queue dut (
        .i_clk_ahb        (clk),
        .i_rstn_ahb       (rstn),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_addr       (req_addr),
        .i_req_rd0_wr1    (req_wr),
        .i_req_wr_data    (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_data       (rsp_data),
        .o_m_valid        (m_valid),
        .o_m_addr         (m_addr),
        .o_m_rd0_wr1      (m_wr),
        .o_m_wr_data      (m_wdata),
        .i_m_ready        (m_ready),
        .i_m_rd_valid     (m_rd_valid),
        .i_m_rd_data      (m_rd_data),
        .o_req_count      (req_count),
        .o_rd_outstanding (rd_out),
        .o_err_unexp_rd   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic wr, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_wr    = wr;
        req_wdata = d;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req_count", 32'(req_count), 0);
        chk("rst_rd_out", 32'(rd_out), 0);
        rstn = 1'b1;
        tick();

        // Write burst, master always ready
        m_ready = 1'b1;
        drive_req(32'h10, 1'b1, 32'hA0);
        chk("wb_no_passthru", 32'(m_valid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb_valid%0d", i), 32'(m_valid), 1);
            chk($sformatf("wb_addr%0d", i), m_addr, 32'h10 + 32'(4*i));
            chk($sformatf("wb_data%0d", i), m_wdata, 32'hA0 + 32'(i));
            chk($sformatf("wb_wr%0d", i), 32'(m_wr), 1);
            chk($sformatf("wb_cnt%0d", i), 32'(req_count), 1);
            if (i < 3) drive_req(32'h14 + 32'(4*i), 1'b1, 32'hA1 + 32'(i));
            else req_valid = 1'b0;
            tick();
        end
        chk("wb_cnt_end", 32'(req_count), 0);
        chk("wb_valid_end", 32'(m_valid), 0);

        // Full request FIFO, master stalled
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_ready%0d", i), 32'(req_ready), (i < 4) ? 1 : 0);
            drive_req(32'h20 + 32'(4*i), 1'b1, 32'hB0 + 32'(i));
            tick();
        end
        chk("full_cnt", 32'(req_count), 4);
        chk("full_ready", 32'(req_ready), 0);
        for (int i = 0; i < 2; i++) begin
            chk("full_hold_valid", 32'(m_valid), 1);
            chk("full_hold_addr", m_addr, 32'h20);
            chk("full_hold_data", m_wdata, 32'hB0);
            tick();
        end
        chk("full_cnt_hold", 32'(req_count), 4);
        m_ready = 1'b1;
        tick();
        chk("full_cnt_pop", 32'(req_count), 3);
        chk("full_addr_pop", m_addr, 32'h24);
        tick();
        req_valid = 1'b0;
        chk("full_cnt_pushpop", 32'(req_count), 3);
        chk("full_addr2", m_addr, 32'h28);
        tick();
        chk("full_addr3", m_addr, 32'h2C);
        tick();
        chk("full_addr4", m_addr, 32'h30);
        chk("full_data4", m_wdata, 32'hB4);
        tick();
        chk("full_drained", 32'(req_count), 0);

        // Read credit: six reads, consumer stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_req(32'h40 + 32'(4*i), 1'b0, 32'h0);
            tick();
        end
        req_valid = 1'b0;
        chk("cr_out4", 32'(rd_out), 4);
        chk("cr_cnt2", 32'(req_count), 2);
        chk("cr_stall", 32'(m_valid), 0);
        for (int i = 0; i < 4; i++) begin
            m_rd_valid = 1'b1;
            m_rd_data  = 32'h11 + 32'(i);
            tick();
            chk($sformatf("cr_rsp_valid%0d", i), 32'(rsp_valid), 1);
            chk($sformatf("cr_rsp_head%0d", i), rsp_data, 32'h11);
            chk($sformatf("cr_out_ret%0d", i), 32'(rd_out), 32'(3 - i));
            chk($sformatf("cr_still_stall%0d", i), 32'(m_valid), 0);
        end
        m_rd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("cr_unstall", 32'(m_valid), 1);
        chk("cr_unstall_addr", m_addr, 32'h50);
        chk("cr_rsp_next", rsp_data, 32'h12);
        tick();
        chk("cr_out_r4", 32'(rd_out), 1);
        chk("cr_r5_stall", 32'(m_valid), 0);
        chk("cr_cnt1", 32'(req_count), 1);
        // Return and consume in the same cycle
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h15;
        rsp_ready  = 1'b1;
        tick();
        m_rd_valid = 1'b0;
        rsp_ready  = 1'b0;
        chk("sim_out0", 32'(rd_out), 0);
        chk("sim_rsp_data", rsp_data, 32'h13);
        chk("sim_r5_valid", 32'(m_valid), 1);
        chk("sim_r5_addr", m_addr, 32'h54);
        tick();
        chk("sim_out_r5", 32'(rd_out), 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sim_drain%0d", i), rsp_data, 32'h13 + 32'(i));
            tick();
        end
        rsp_ready = 1'b0;
        chk("sim_rsp_empty", 32'(rsp_valid), 0);
        // Issue a read while another returns
        m_ready = 1'b0;
        drive_req(32'h60, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("sim_r6_valid", 32'(m_valid), 1);
        m_ready    = 1'b1;
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h16;
        tick();
        chk("sim_issue_ret_out", 32'(rd_out), 1);
        chk("sim_issue_ret_data", rsp_data, 32'h16);
        m_rd_data = 32'h17;
        tick();
        m_rd_valid = 1'b0;
        chk("sim_out_final", 32'(rd_out), 0);
        rsp_ready = 1'b1;
        chk("sim_order0", rsp_data, 32'h16);
        tick();
        chk("sim_order1", rsp_data, 32'h17);
        tick();
        rsp_ready = 1'b0;

        // Ordering: fill the response FIFO, then W,R,W,R,R
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h70 + 32'(4*i), 1'b0, 32'h0);
            tick();
        end
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            m_rd_valid = 1'b1;
            m_rd_data  = 32'h21 + 32'(i);
            tick();
        end
        m_rd_valid = 1'b0;
        chk("ord_out0", 32'(rd_out), 0);
        drive_req(32'h80, 1'b1, 32'hC0); tick();
        drive_req(32'h84, 1'b0, 32'h0);  tick();
        drive_req(32'h88, 1'b1, 32'hC2); tick();
        drive_req(32'h8C, 1'b0, 32'h0);  tick();
        drive_req(32'h90, 1'b0, 32'h0);  tick();
        req_valid = 1'b0;
        tick();
        chk("ord_cnt", 32'(req_count), 4);
        chk("ord_stall", 32'(m_valid), 0);
        chk("ord_head", m_addr, 32'h84);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ord_r_valid", 32'(m_valid), 1);
        chk("ord_r_addr", m_addr, 32'h84);
        tick();
        chk("ord_w_addr", m_addr, 32'h88);
        chk("ord_w_valid", 32'(m_valid), 1);
        tick();
        chk("ord_r2_addr", m_addr, 32'h8C);
        chk("ord_r2_stall", 32'(m_valid), 0);
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h31;
        tick();
        m_rd_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ord_rsp%0d", i), rsp_data, (i < 3) ? 32'h22 + 32'(i) : 32'h31);
            tick();
        end
        rsp_ready = 1'b0;
        chk("ord_out2", 32'(rd_out), 2);
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h32; tick();
        m_rd_data  = 32'h33; tick();
        m_rd_valid = 1'b0;
        rsp_ready  = 1'b1;
        chk("ord_tail0", rsp_data, 32'h32);
        tick();
        chk("ord_tail1", rsp_data, 32'h33);
        tick();
        rsp_ready = 1'b0;
        chk("ord_err_clean", 32'(err), 0);

        // Unexpected read data
        m_rd_valid = 1'b1;
        m_rd_data  = 32'hDEAD;
        tick();
        m_rd_valid = 1'b0;
        chk("err_set", 32'(err), 1);
        chk("err_dropped", 32'(rsp_valid), 0);
        chk("err_out0", 32'(rd_out), 0);
        tick();
        tick();
        chk("err_sticky", 32'(err), 1);

        // Reset in the middle of a burst
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(32'hA0 + 32'(4*i), 1'b1, 32'hD0 + 32'(i));
            tick();
        end
        req_valid = 1'b0;
        chk("mid_cnt", 32'(req_count), 3);
        chk("mid_valid", 32'(m_valid), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_cnt", 32'(req_count), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_addr", m_addr, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_rst_valid", 32'(m_valid), 0);
        chk("post_rst_out", 32'(rd_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
